fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end with a prefetch queue; replaces the single PC/adder/mux fetch path.
//  Owns the PC, reads a combinational instruction memory every cycle, and queues {instr, pc_next} pairs.
//  Decode consumes them through a valid/ready handshake.
//  Redirects from branch/jump resolution flush the queue; halt stops fetch while the queue drains.
// PARAMETERS
//  ADDR_W    16      PC / instruction-address width
//  INSTR_W   16      instruction width
//  DEPTH     4       prefetch queue entries; power of 2, >=2
//  PC_STEP   2       bytes added to PC per sequential fetch
//  RESET_PC  16'h0   PC value after reset
// PORTS
//  clock          in   1              rising-edge clock
//  reset          in   1              synchronous, active-high
//  imem_addr      out  ADDR_W         fetch address; equals the PC register
//  imem_rdata     in   INSTR_W        instruction at imem_addr, same cycle (combinational memory)
//  redirect_valid in   1              branch/jump taken this cycle
//  redirect_addr  in   ADDR_W         new PC on redirect
//  halt_req       in   1              stop fetching; sticky until redirect or reset
//  out_valid      out  1              queue head valid
//  out_instr      out  INSTR_W        head instruction
//  out_pc_next    out  ADDR_W         head fetch address + PC_STEP
//  out_ready      in   1              decode accepts head (pop when out_valid & out_ready)
//  halted         out  1              halt latched
//  count          out  $clog2(DEPTH)+1  queue occupancy
// BEHAVIOUR
//  Reset (sync): pc=RESET_PC, queue empty, count=0, out_valid=0, halted=0.
//   out_instr / out_pc_next = 0 while empty.
//  fetch_en = !halted & !redirect_valid & (count<DEPTH | pop).
//   The full-and-pop case allows a same-cycle push.
//  On fetch_en:
//   - push {imem_rdata, pc+PC_STEP}
//   - pc <= pc+PC_STEP, modulo 2^ADDR_W (wraps, no error)
//  Otherwise pc holds.
//  Output timing: the push becomes visible at the head next cycle. Fetch-to-out_valid latency is 1 cycle. No bypass.
//  Pop: head advances on out_valid & out_ready; out_ready while empty is ignored.
//  Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
//  Redirect (highest priority below reset):
//   - queue cleared; count=0 next cycle
//   - pc <= redirect_addr
//   - halted <= 0
//   - no push that cycle; any pop that cycle is discarded with the flush
//   - first redirected instruction is valid at the head 2 cycles after the redirect cycle
//  halt_req=1 with no redirect:
//   - halted <= 1; suppresses fetch starting the same cycle
//   - queued entries keep draining normally
//  Reset asserted mid-operation overrides redirect, halt, push and pop.
//  count is never > DEPTH and never underflows.
//  Handshake stability: out_instr / out_pc_next are stable while out_valid & !out_ready (no redirect).
// STRUCTURE
//  Shared package (fetch_pkg):
//   - RESET_PC default
//   - PC_STEP default
//   - typedef fetch_entry_t = {instr, pc_next}
//  One sub-module, sync_fifo_flush (WIDTH, DEPTH):
//   - push / pop / flush
//   - full, empty, count
//   - registered head output
//  Top level holds the PC register, halt flag, fetch_en logic and next-PC mux.
// TESTING
//  1. Reset, out_ready=1, imem[0,2,4]=A,B,C
//     -> out_valid from cycle 2; heads A/2, B/4, C/6 on consecutive cycles.
//  2. out_ready=0 for 8 cycles, DEPTH=4
//     -> count reaches 4 and holds; imem_addr frozen at 8.
//     Then out_ready=1 -> one pop plus one push per cycle; count stays 4.
//  3. Redirect to 16'h0040 while count=3
//     -> count=0 next cycle; imem_addr=0x0040.
//     Head = imem[0x40] with pc_next=0x42 two cycles later.
//  4. halt_req pulse with count=2, out_ready=1
//     -> two more heads, then out_valid=0; halted=1; PC frozen.
//     Redirect then clears halted and fetching resumes.
//  5. RESET_PC=16'hFFFE
//     -> second fetch address 0x0000 (wrap); out_pc_next of first entry = 0x0000.
//  6. reset asserted while full and redirect_valid=1
//     -> next cycle count=0, pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end.
//   - DEF_* : default widths, PC step and reset PC used by fetch_queue_unit
//   - fetch_entry_t : {instr, pc_next} record at the default widths, the
//     layout stored in the prefetch queue (instr in the upper bits)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_PC_STEP  = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// -----------------------------------------------------------------------------
// sync_fifo_flush
//   Synchronous FIFO with a single-cycle flush. The head entry is read
//   straight out of the storage registers, so a push becomes visible at the
//   head on the cycle after it is written (no bypass).
// Ports
//   clk_i    in   clock (rising edge)
//   rst_i    in   synchronous active-high reset
//   flush_i  in   discard all entries; wins over push and pop
//   push_i   in   write data_i (accepted when not full, or when popping)
//   data_i   in   WIDTH-bit entry
//   pop_i    in   advance the head (ignored while empty)
//   head_o   out  head entry, all zeros while empty
//   full_o   out  occupancy == DEPTH
//   empty_o  out  occupancy == 0
//   count_o  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_flush #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end with a prefetch queue. Owns the PC, reads a
//   combinational instruction memory every cycle and queues {instr, pc_next}
//   pairs for decode. Redirects flush the queue and load a new PC; halt stops
//   fetching while already-queued entries drain.
// Ports
//   clock           in   rising-edge clock
//   reset           in   synchronous active-high reset
//   imem_addr       out  fetch address (the PC register)
//   imem_rdata      in   instruction at imem_addr, same cycle
//   redirect_valid  in   branch/jump taken this cycle
//   redirect_addr   in   new PC on redirect
//   halt_req        in   stop fetching; sticky until redirect or reset
//   out_valid       out  queue head valid
//   out_instr       out  head instruction (0 while empty)
//   out_pc_next     out  head fetch address + PC_STEP (0 while empty)
//   out_ready       in   decode accepts the head
//   halted          out  halt latched
//   count           out  queue occupancy
//
// Handshake: the head transfers on a cycle where out_valid & out_ready are
// both high at the rising edge. While out_valid is high and out_ready is low,
// out_instr / out_pc_next hold their value (unless a redirect flushes the
// queue). out_ready while out_valid is low has no effect.
// -----------------------------------------------------------------------------
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_addr,
  input  logic                   halt_req,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc_next,
  input  logic                   out_ready,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  pc_seq;
  logic               pop, fetch_en;
  logic               q_full, q_empty;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  assign pc_seq = pc_q + PC_STEP;   // wraps modulo 2^ADDR_W

  assign pop = out_valid & out_ready;

  // halt_req blocks fetch in the cycle it arrives, before halted_q is set.
  // A full queue may still fetch when the head pops this cycle.
  assign fetch_en = ~halted_q & ~halt_req & ~redirect_valid & (~q_full | pop);

  // Same {instr, pc_next} layout as fetch_entry_t, at this instance's widths.
  assign push_entry = {imem_rdata, pc_seq};

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_addr;
      halted_d = 1'b0;
    end else begin
      if (fetch_en) pc_d = pc_seq;
      if (halt_req) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // A pop coinciding with a redirect is simply lost in the flush.
  sync_fifo_flush #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (fetch_en),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (count)
  );

  assign out_valid   = ~q_empty;
  assign out_instr   = head_entry[ENTRY_W-1:ADDR_W];
  assign out_pc_next = head_entry[ADDR_W-1:0];
  assign imem_addr   = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//   Directed, table-driven bench for fetch_queue_unit. Each table row holds
//   the inputs for one cycle and the outputs expected during that cycle.
//   A second instance with RESET_PC = 16'hFFFE covers PC wrap-around.
//   Instruction memory model: imem[a] = 16'hC000 | a.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        halt_req;
  logic        out_ready;

  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc_next;
  logic        out_valid, halted;
  logic [2:0]  count;

  logic [15:0] imem_addr2, imem_rdata2, out_instr2, out_pc_next2;
  logic        out_valid2, halted2;
  logic [2:0]  count2;

  function automatic logic [15:0] imem_f(input logic [15:0] a);
    return 16'hC000 | a;
  endfunction

  assign imem_rdata  = imem_f(imem_addr);
  assign imem_rdata2 = imem_f(imem_addr2);

  fetch_queue_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc_next    (out_pc_next),
    .out_ready      (out_ready),
    .halted         (halted),
    .count          (count)
  );

  fetch_queue_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .out_valid      (out_valid2),
    .out_instr      (out_instr2),
    .out_pc_next    (out_pc_next2),
    .out_ready      (out_ready),
    .halted         (halted2),
    .count          (count2)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [15:0] raddr;
    logic        halt;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] ep;
    logic [2:0]  ec;
    logic        eh;
    logic [15:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [15:0] raddr, input logic halt,
                              input logic ev, input logic [15:0] ei,
                              input logic [15:0] ep, input logic [2:0] ec,
                              input logic eh, input logic [15:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.raddr = raddr; v.halt = halt;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.eh = eh; v.ea = ea;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //                 rst rdy rv raddr    hlt  ev  instr     pc_next   cnt eh  addr
    // sequential fetch, out_ready high (ready while empty is ignored)
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 1, 0, 16'h0002));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC002, 16'h0004, 1, 0, 16'h0004));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0,  1, 16'hC004, 16'h0006, 1, 0, 16'h0006));
    // back-pressure: fill to DEPTH, PC freezes at 8, head stable
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 1, 0, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 2, 0, 16'h0004));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 3, 0, 16'h0006));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 4, 0, 16'h0008));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 4, 0, 16'h0008));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 4, 0, 16'h0008));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 4, 0, 16'h0008));
    // full + pop: one push and one pop per cycle, count stays 4
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 4, 0, 16'h0008));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC002, 16'h0004, 4, 0, 16'h000A));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC004, 16'h0006, 4, 0, 16'h000C));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0,  1, 16'hC004, 16'h0006, 4, 0, 16'h000C));
    // redirect to 0x0040 with count 3 (pop in the same cycle is discarded)
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 1, 0, 16'h0002));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC000, 16'h0002, 2, 0, 16'h0004));
    tbl.push_back(mk(0, 1, 1, 16'h0040, 0,  1, 16'hC000, 16'h0002, 3, 0, 16'h0006));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0040));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC040, 16'h0042, 1, 0, 16'h0042));
    // halt pulse with count 2: two heads drain, PC frozen, redirect resumes
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC042, 16'h0044, 1, 0, 16'h0044));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1,  1, 16'hC042, 16'h0044, 2, 0, 16'h0046));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  1, 16'hC044, 16'h0046, 1, 1, 16'h0046));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 1, 16'h0046));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 1, 16'h0046));
    tbl.push_back(mk(0, 1, 1, 16'h0100, 0,  0, 16'h0000, 16'h0000, 0, 1, 16'h0046));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0100));
    // fill again, then reset together with redirect and halt
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC100, 16'h0102, 1, 0, 16'h0102));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC100, 16'h0102, 2, 0, 16'h0104));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC100, 16'h0102, 3, 0, 16'h0106));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0,  1, 16'hC100, 16'h0102, 4, 0, 16'h0108));
    tbl.push_back(mk(1, 1, 1, 16'h0200, 1,  1, 16'hC100, 16'h0102, 4, 0, 16'h0108));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0,  0, 16'h0000, 16'h0000, 0, 0, 16'h0000));

    // initial reset
    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    halt_req = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // apply the table: drive after the edge, sample on the falling edge
    for (int i = 0; i < tbl.size(); i++) begin
      reset          = tbl[i].rst;
      out_ready      = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_addr  = tbl[i].raddr;
      halt_req       = tbl[i].halt;
      @(negedge clock);
      chk($sformatf("v%0d out_valid",   i), 32'(out_valid),   32'(tbl[i].ev));
      chk($sformatf("v%0d out_instr",   i), 32'(out_instr),   32'(tbl[i].ei));
      chk($sformatf("v%0d out_pc_next", i), 32'(out_pc_next), 32'(tbl[i].ep));
      chk($sformatf("v%0d count",       i), 32'(count),       32'(tbl[i].ec));
      chk($sformatf("v%0d halted",      i), 32'(halted),      32'(tbl[i].eh));
      chk($sformatf("v%0d imem_addr",   i), 32'(imem_addr),   32'(tbl[i].ea));
      step();
    end

    // PC wrap: instance with RESET_PC = 0xFFFE
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
    step();
    reset = 1'b0;
    exp_q.push_back({16'hFFFE, 16'h0000});
    exp_q.push_back({16'hC000, 16'h0002});
    @(negedge clock);
    chk("wrap first addr", 32'(imem_addr2), 32'h0000_FFFE);
    chk("wrap empty",      32'(out_valid2), 32'd0);
    step();
    @(negedge clock);
    chk("wrap second addr", 32'(imem_addr2), 32'h0000_0000);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e;
      if (k > 0) @(negedge clock);
      e = exp_q.pop_front();
      chk($sformatf("wrap head%0d valid", k), 32'(out_valid2), 32'd1);
      chk($sformatf("wrap head%0d entry", k), {out_instr2, out_pc_next2}, e);
      step();
    end
    @(negedge clock);
    chk("wrap count", 32'(count2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
